// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the data-memory responder
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_t;

    localparam logic [3:0] BE_BYTE0 = 4'b0001;
    localparam logic [3:0] BE_BYTE1 = 4'b0010;
    localparam logic [3:0] BE_BYTE2 = 4'b0100;
    localparam logic [3:0] BE_BYTE3 = 4'b1000;
    localparam logic [3:0] BE_HALF0 = 4'b0011;
    localparam logic [3:0] BE_HALF1 = 4'b1100;
    localparam logic [3:0] BE_WORD  = 4'b1111;

    localparam logic [31:0] DATA_BASE = 32'h0000_0000;

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] pc;
    } dm_req_t;

    // Halfword lanes must be halfword aligned, full words word aligned.
    function automatic logic be_illegal(input logic [3:0] be, input logic [1:0] addr_lo);
        case (be)
            BE_BYTE0, BE_BYTE1, BE_BYTE2, BE_BYTE3: return 1'b0;
            BE_HALF0, BE_HALF1:                     return addr_lo[0];
            BE_WORD:                                return addr_lo != 2'b00;
            default:                                return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dm_responder_if.sv
// rtl/dm_responder_if.sv - request/acknowledge memory port between core and responder
interface dm_responder_if;
    logic        Req_In;
    logic        We_In;
    logic [3:0]  Be_In;
    logic [31:0] Addr_In;
    logic [31:0] D_In;
    logic [31:0] Pc_In;
    logic        Busy_Out;
    logic        Ack_Out;
    logic [31:0] D_Out;
    logic        Err_Out;

    modport master (
        output Req_In, We_In, Be_In, Addr_In, D_In, Pc_In,
        input  Busy_Out, Ack_Out, D_Out, Err_Out
    );

    modport slave (
        input  Req_In, We_In, Be_In, Addr_In, D_In, Pc_In,
        output Busy_Out, Ack_Out, D_Out, Err_Out
    );
endinterface

// File: rtl/dm_byte_merge.sv
// rtl/dm_byte_merge.sv - replaces enabled byte lanes of a word with lane-aligned store data
module dm_byte_merge (
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [3:0]  be,
    output logic [31:0] merged_word
);
    always_comb begin
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                merged_word[8*i +: 8] = new_data[8*i +: 8];
            end
        end
    end
endmodule

// File: rtl/dm_responder.sv
// rtl/dm_responder.sv - multi-cycle load/store responder with wait states and error flagging
module dm_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic           Clk,
    input  logic           Reset,
    dm_responder_if.slave  bus
);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    dm_state_t   state, next_state;
    logic [3:0]  cnt, cnt_next;
    dm_req_t     req_q, req_in, cur;
    logic        err_q;
    logic [31:0] d_q;
    logic        enter_resp;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]       off;
    logic [ADDR_W-1:0] idx;
    logic              range_err;
    logic              cur_err;
    logic [31:0]       merged;
    logic              commit;

    assign req_in = '{we: bus.We_In, be: bus.Be_In, addr: bus.Addr_In,
                      data: bus.D_In, pc: bus.Pc_In};

    // With zero wait states RESP is entered on the acceptance edge, so the
    // error and read must be evaluated on the live request in IDLE.
    assign cur       = (state == ST_IDLE) ? req_in : req_q;
    assign off       = cur.addr - DATA_BASE;
    assign idx       = off[ADDR_W+1:2];
    assign range_err = (off[31:ADDR_W+2] != '0) || (32'(idx) >= 32'(DEPTH_WORDS));
    assign cur_err   = range_err || (cur.we && be_illegal(cur.be, cur.addr[1:0]));

    dm_byte_merge u_merge (
        .old_word    (mem[idx]),
        .new_data    (req_q.data),
        .be          (req_q.be),
        .merged_word (merged)
    );

    assign commit = (state == ST_RESP) && req_q.we && !err_q;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        enter_resp = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.Req_In) begin
                    cnt_next = WAIT_INIT;
                    if (WAIT_INIT == 4'd0) begin
                        next_state = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    next_state = ST_RESP;
                    enter_resp = 1'b1;
                end
            end
            ST_RESP: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            req_q <= '0;
            err_q <= 1'b0;
            d_q   <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                mem[i] <= '0;
            end
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            if (state == ST_IDLE && bus.Req_In) begin
                req_q <= req_in;
            end
            if (enter_resp) begin
                err_q <= cur_err;
                if (cur_err) begin
                    d_q <= '0;
                end else if (!cur.we) begin
                    d_q <= mem[idx];
                end
            end
            if (commit) begin
                mem[idx] <= merged;
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge Clk) begin
        if (Reset && commit) begin
            $display("@%h: *%h <= %h", req_q.pc, {req_q.addr[31:2], 2'b00}, merged);
        end
    end
`endif

    assign bus.Busy_Out = (state != ST_IDLE);
    assign bus.Ack_Out  = (state == ST_RESP);
    assign bus.Err_Out  = (state == ST_RESP) && err_q;
    assign bus.D_Out    = d_q;

endmodule

// File: tb/tb_dm_responder.sv
// tb/tb_dm_responder.sv - scoreboard bench for dm_responder with 2 and 0 wait states
module tb_dm_responder;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst2, rst0;
    always #5 clk = ~clk;

    dm_responder_if bus2();
    dm_responder_if bus0();

    dm_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
        .Clk(clk), .Reset(rst2), .bus(bus2));
    dm_responder #(.DEPTH_WORDS(DEPTH), .ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
        .Clk(clk), .Reset(rst0), .bus(bus0));

    typedef struct {
        logic        err;
        logic [31:0] dout;
        int          cyc;
    } exp_t;

    exp_t q2[$];
    exp_t q0[$];

    logic [31:0] mm [2][DEPTH];
    logic [31:0] md [2];

    int cyc = 0;
    int checks = 0;
    int failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int waits(input int w);
        return (w == 0) ? 2 : 0;
    endfunction

    // Reference behaviour: bytes address a flat array of DEPTH*4 bytes.
    task automatic model_access(input int w, input logic we, input logic [3:0] be,
                                input logic [31:0] addr, input logic [31:0] data,
                                output logic err, output logic [31:0] dout);
        logic [31:0] word;
        int wi;
        err = (addr >= 32'(DEPTH * 4));
        if (we) begin
            if (!(be inside {4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd12, 4'd15})) err = 1'b1;
            if ((be == 4'd3 || be == 4'd12) && (addr % 2 != 0)) err = 1'b1;
            if (be == 4'd15 && (addr % 4 != 0)) err = 1'b1;
        end
        if (err) begin
            md[w] = 32'h0;
        end else if (we) begin
            wi = int'(addr / 4);
            word = mm[w][wi];
            for (int b = 0; b < 4; b++)
                if (be[b]) word[8*b +: 8] = data[8*b +: 8];
            mm[w][wi] = word;
        end else begin
            md[w] = mm[w][int'(addr / 4)];
        end
        dout = md[w];
    endtask

    task automatic drive(input int w, input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] data, input logic [31:0] pc);
        if (w == 0) begin
            bus2.Req_In = req; bus2.We_In = we; bus2.Be_In = be;
            bus2.Addr_In = addr; bus2.D_In = data; bus2.Pc_In = pc;
        end else begin
            bus0.Req_In = req; bus0.We_In = we; bus0.Be_In = be;
            bus0.Addr_In = addr; bus0.D_In = data; bus0.Pc_In = pc;
        end
    endtask

    task automatic do_req(input int w, input logic we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] data, input logic [31:0] pc);
        exp_t e;
        logic got;
        @(negedge clk);
        drive(w, 1'b1, we, be, addr, data, pc);
        model_access(w, we, be, addr, data, e.err, e.dout);
        e.cyc = cyc + 1 + waits(w);
        if (w == 0) q2.push_back(e); else q0.push_back(e);
        got = 1'b0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            got = (w == 0) ? bus2.Ack_Out : bus0.Ack_Out;
        end
        drive(w, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        if (!got) check("ack_timeout", {31'h0, got}, 32'h1);
    endtask

    task automatic monitor(input int w);
        exp_t e;
        logic ack, err;
        logic [31:0] dout;
        forever begin
            @(negedge clk);
            ack  = (w == 0) ? bus2.Ack_Out : bus0.Ack_Out;
            err  = (w == 0) ? bus2.Err_Out : bus0.Err_Out;
            dout = (w == 0) ? bus2.D_Out   : bus0.D_Out;
            if (ack) begin
                if ((w == 0 && q2.size() == 0) || (w == 1 && q0.size() == 0)) begin
                    check($sformatf("unexpected_ack_w%0d", waits(w)), {31'h0, ack}, 32'h0);
                end else begin
                    e = (w == 0) ? q2.pop_front() : q0.pop_front();
                    check($sformatf("err_w%0d", waits(w)), {31'h0, err}, {31'h0, e.err});
                    check($sformatf("dout_w%0d", waits(w)), dout, e.dout);
                    check($sformatf("ack_cycle_w%0d", waits(w)), 32'(cyc), 32'(e.cyc));
                end
            end else begin
                check($sformatf("err_without_ack_w%0d", waits(w)), {31'h0, err}, 32'h0);
            end
        end
    endtask

    task automatic random_req(input int w);
        logic [31:0] a;
        a = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 7) == 0) a = $urandom;
        do_req(w, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom, $urandom);
    endtask

    initial begin
        exp_t e;
        int k;
        for (int i = 0; i < DEPTH; i++) begin
            mm[0][i] = 32'h0;
            mm[1][i] = 32'h0;
        end
        md[0] = 32'h0;
        md[1] = 32'h0;
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        rst2 = 1'b0;
        rst0 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_busy", {31'h0, bus2.Busy_Out}, 32'h0);
        check("rst_ack", {31'h0, bus2.Ack_Out}, 32'h0);
        check("rst_err", {31'h0, bus2.Err_Out}, 32'h0);
        check("rst_dout", bus2.D_Out, 32'h0);
        check("rst_busy_w0", {31'h0, bus0.Busy_Out}, 32'h0);
        rst2 = 1'b1;
        rst0 = 1'b1;
        fork
            monitor(0);
            monitor(1);
        join_none

        do_req(0, 1'b0, 4'hF, 32'h0, 32'h0, 32'h1000);
        do_req(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'h3008);
        do_req(0, 1'b0, 4'h0, 32'h10, 32'h0, 32'h300C);
        do_req(0, 1'b1, 4'hC, 32'h12, 32'h12340000, 32'h3010);
        do_req(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h3014);
        do_req(0, 1'b1, 4'hA, 32'h10, 32'hFFFFFFFF, 32'h3018);
        do_req(0, 1'b0, 4'hF, 32'h10, 32'h0, 32'h301C);
        do_req(0, 1'b0, 4'hF, 32'h1000, 32'h0, 32'h3020);
        do_req(0, 1'b1, 4'h3, 32'h11, 32'h5555, 32'h3024);
        do_req(0, 1'b1, 4'hF, 32'h16, 32'h1, 32'h3028);
        for (int i = 0; i < 40; i++) random_req(0);

        // Reset lands in the first WAIT cycle of a store: no ack, no write.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 4'hF, 32'h20, 32'hCAFEF00D, 32'h4000);
        @(negedge clk);
        check("wait_busy", {31'h0, bus2.Busy_Out}, 32'h1);
        drive(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);
        rst2 = 1'b0;
        @(negedge clk);
        rst2 = 1'b1;
        check("post_rst_busy", {31'h0, bus2.Busy_Out}, 32'h0);
        check("post_rst_ack", {31'h0, bus2.Ack_Out}, 32'h0);
        for (int i = 0; i < DEPTH; i++) mm[0][i] = 32'h0;
        md[0] = 32'h0;
        do_req(0, 1'b0, 4'hF, 32'h20, 32'h0, 32'h4004);

        for (int i = 0; i < 30; i++) random_req(1);
        do_req(1, 1'b1, 4'hF, 32'h4, 32'hA5A55A5A, 32'h5000);

        // Request held high with zero wait states: one ack every second cycle.
        @(negedge clk);
        k = cyc;
        drive(1, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0, 32'h5004);
        for (int j = 0; j < 5; j++) begin
            model_access(1, 1'b0, 4'hF, 32'h4, 32'h0, e.err, e.dout);
            e.cyc = k + 1 + 2 * j;
            q0.push_back(e);
        end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check($sformatf("hold_busy_%0d", i), {31'h0, bus0.Busy_Out}, 32'(i % 2));
        end
        drive(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0);

        repeat (4) @(negedge clk);
        check("q_drain_w2", 32'(q2.size()), 32'h0);
        check("q_drain_w0", 32'(q0.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
